// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, data/counter widths and the default depth.
// Optional error reporting is selected in data_memory_responder via DMEM_ERR_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 32;
  localparam int DMEM_CNT_W  = 4;

  // Countdown start value: the access happens once the counter has drained to
  // zero, so a latency of N edges needs N-1 decrements after acceptance.
  function automatic logic [DMEM_CNT_W-1:0] dmem_cnt_init(input int latency);
    return DMEM_CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage for the data-memory responder.
// Write is committed on the clock edge with we_i; read data is registered on re_i.
// rclr_i forces the registered read data to zero (used for rejected reads).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic                   re_i,
  input  logic                   rclr_i,
  input  logic [AW-1:0]          idx_i,
  input  logic [DMEM_DATA_W-1:0] wdata_i,
  output logic [DMEM_DATA_W-1:0] rdata_o
);

  logic [DMEM_DATA_W-1:0] r_mem [DEPTH];
  logic [DMEM_DATA_W-1:0] r_rdata;

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[idx_i] <= wdata_i;
    end
  end

  // Read register holds the last read value until the next read access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
    end else if (re_i) begin
      r_rdata <= rclr_i ? '0 : r_mem[idx_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: accepts a word request, waits LATENCY edges,
// accesses dmem_array, returns a one-cycle ack; busy_o stalls the pipeline in WAIT.
// Optional macro DMEM_ERR_EN adds err_o for misaligned / out-of-range addresses.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        busy_o
`ifdef DMEM_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DMEM_CNT_W-1:0] CNT_INIT = dmem_cnt_init(LATENCY);

  dmem_state_t            r_state;
  logic [DMEM_CNT_W-1:0]  r_cnt;
  logic                   r_we;
  logic [AW-1:0]          r_idx;
  logic [DMEM_DATA_W-1:0] r_wdata;
  logic                   r_err;
  logic                   r_ack;
`ifdef DMEM_ERR_EN
  logic                   r_err_o;
`endif

  logic                   w_access;
  logic                   w_req_err;
  logic                   w_arr_we;
  logic                   w_arr_re;
  logic [DMEM_DATA_W-1:0] w_arr_rdata;

  // Word index from the byte address; bits above the array size are dropped so
  // addresses wrap modulo DEPTH*4 when error reporting is not built in.
`ifdef DMEM_ERR_EN
  assign w_req_err = (addr_i[1:0] != 2'b00) || (addr_i[31:AW+2] != '0);
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
  assign w_req_err     = 1'b0;
`endif

  // The access edge is the last edge spent in WAIT.
  assign w_access = (r_state == WAIT) && (r_cnt == '0);
  assign w_arr_we = w_access && r_we && !r_err;
  assign w_arr_re = w_access && !r_we;

  // Request FSM: latch in IDLE, count down in WAIT, pulse ack in RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
`ifdef DMEM_ERR_EN
      r_err_o <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
`ifdef DMEM_ERR_EN
      r_err_o <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_idx   <= addr_i[AW+1:2];
            r_wdata <= wdata_i;
            r_err   <= w_req_err;
            r_cnt   <= CNT_INIT;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DMEM_CNT_W'(1);
          end else begin
            r_ack   <= 1'b1;
`ifdef DMEM_ERR_EN
            r_err_o <= r_err;
`endif
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (w_arr_we),
    .re_i    (w_arr_re),
    .rclr_i  (r_err),
    .idx_i   (r_idx),
    .wdata_i (r_wdata),
    .rdata_o (w_arr_rdata)
  );

  assign rdata_o = w_arr_rdata;
  assign ack_o   = r_ack;
  assign busy_o  = (r_state == WAIT);
`ifdef DMEM_ERR_EN
  assign err_o   = r_err_o;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a LATENCY=2 instance for functional
// cases and a LATENCY=1 instance for held-request back-to-back timing.
// Build with DMEM_ERR_EN defined to also cover the error-reporting variant.
module tb_data_memory_responder;

  logic        clk;
  logic        rst;

  logic        req2, we2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        ack2, busy2;
  logic        req1, we1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ack1, busy1;
`ifdef DMEM_ERR_EN
  logic        err2, err1;
`endif

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] last_rd2;

  data_memory_responder #(.DEPTH(32), .LATENCY(2)) u_dut2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req2),
    .we_i    (we2),
    .addr_i  (addr2),
    .wdata_i (wdata2),
    .rdata_o (rdata2),
    .ack_o   (ack2),
    .busy_o  (busy2)
`ifdef DMEM_ERR_EN
    ,
    .err_o   (err2)
`endif
  );

  data_memory_responder #(.DEPTH(32), .LATENCY(1)) u_dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req1),
    .we_i    (we1),
    .addr_i  (addr1),
    .wdata_i (wdata1),
    .rdata_o (rdata1),
    .ack_o   (ack1),
    .busy_o  (busy1)
`ifdef DMEM_ERR_EN
    ,
    .err_o   (err1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One complete access on the LATENCY=2 instance, counting edges from the
  // accepting edge (edge 1) to the edge after which ack is seen.
  task automatic access2(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err);
    int n     = 0;
    int nbusy = 0;
    bit seen  = 0;
    req2 = 1'b1; we2 = we; addr2 = addr; wdata2 = wdata;
    while (!seen && n < 16) begin
      step();
      n++;
      if (busy2) nbusy++;
      if (ack2) seen = 1;
    end
    req2 = 1'b0;
    check({tag, "_ack_edge"}, n, 3);
    check({tag, "_busy_cycles"}, nbusy, 2);
    if (we) begin
      check({tag, "_rdata_held"}, rdata2, last_rd2);
    end else begin
      check({tag, "_rdata"}, rdata2, exp_rd);
      last_rd2 = exp_rd;
    end
`ifdef DMEM_ERR_EN
    check({tag, "_err"}, err2, exp_err);
`else
    if (exp_err) $display("note: %s would flag an error with DMEM_ERR_EN", tag);
`endif
    step();
    check({tag, "_ack_drop"}, ack2, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    last_rd2 = '0;

    repeat (2) step();
    check("reset_ack", ack2, 1'b0);
    check("reset_busy", busy2, 1'b0);
    check("reset_rdata", rdata2, 32'h0);
    rst = 1'b0;
    step();

    // Basic write then read-back of the same word.
    access2("wr_08", 1'b1, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0);
    access2("rd_08", 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0);

    // Address wrap: 0x80 aliases word 0 unless it is rejected as out of range.
    access2("wr_00", 1'b1, 32'h0, 32'h22, 32'h0, 1'b0);
    access2("wr_80", 1'b1, 32'h80, 32'h11, 32'h0, 1'b1);
`ifdef DMEM_ERR_EN
    access2("rd_00_wrap", 1'b0, 32'h0, 32'h0, 32'h22, 1'b0);
`else
    access2("rd_00_wrap", 1'b0, 32'h0, 32'h0, 32'h11, 1'b0);
`endif

    // Reset during WAIT of a write: nothing committed, no ack.
    access2("wr_04", 1'b1, 32'h4, 32'h0A0A0A0A, 32'h0, 1'b0);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h4; wdata2 = 32'h55;
    step();
    check("abort_busy_e1", busy2, 1'b1);
    step();
    check("abort_busy_e2", busy2, 1'b1);
    check("abort_ack_e2", ack2, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_rst_ack", ack2, 1'b0);
    check("abort_rst_busy", busy2, 1'b0);
    check("abort_rst_rdata", rdata2, 32'h0);
    req2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_ack", ack2, 1'b0);
    end
    rst = 1'b0;
    last_rd2 = '0;
    step();
    check("abort_post_ack", ack2, 1'b0);
    access2("rd_04_old", 1'b0, 32'h4, 32'h0, 32'h0A0A0A0A, 1'b0);

`ifdef DMEM_ERR_EN
    access2("rd_06_err", 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
    access2("wr_100_err", 1'b1, 32'h100, 32'h99, 32'h0, 1'b1);
    access2("rd_00_kept", 1'b0, 32'h0, 32'h0, 32'h22, 1'b0);
`endif

    // LATENCY=1, request held high: accept, access, ack, back to IDLE, re-accept.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'hC; wdata1 = 32'h12345678;
    for (int k = 0; k < 9; k++) begin
      step();
      check($sformatf("l1_wr_ack_%0d", k), ack1, (k % 3) == 1);
      check($sformatf("l1_wr_busy_%0d", k), busy1, (k % 3) == 0);
    end
    req1 = 1'b0;
    step();
    we1 = 1'b0;
    req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("l1_rd_ack_%0d", k), ack1, (k % 3) == 1);
      check($sformatf("l1_rd_busy_%0d", k), busy1, (k % 3) == 0);
      if ((k % 3) == 1) check($sformatf("l1_rd_data_%0d", k), rdata1, 32'h12345678);
    end
    req1 = 1'b0;
    step();
    check("l1_idle_ack", ack1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
